sonar_rx_quadro: RTL
====================

Name: sonar_rx_quadro

Overview:
- Receiving end of the sonar's serial link: deserializes 8N1 UART bytes and parses the sonar's ASCII frame "AAA,DDDD#" into a 3-digit BCD angle and a 4-digit BCD distance.
- Sits on the host/monitor board, fed by the sonar's TX line.
- Flags each good frame with a pulse, flags malformed frames, and resynchronizes on the '#' terminator.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIV, CLK_HZ/BAUD (434), clocks per bit; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilita  in  1  receiver enable; 0 holds the frame FSM in inicial and discards bytes.
- rx  in  1  serial input, idle high, asynchronous to clock.
- angulo  out  12  BCD angle, hundreds in [11:8]; holds last valid frame.
- distancia  out  16  BCD distance, thousands in [15:12]; holds last valid frame.
- quadro_pronto  out  1  1-cycle pulse when a valid frame is published.
- erro_quadro  out  1  1-cycle pulse on a malformed frame or bad stop bit.
- db_estado  out  4  frame FSM state code, for debug.

Behaviour:
- Reset (reset=0, async): angulo=0, distancia=0, quadro_pronto=0, erro_quadro=0, db_estado=0. Byte RX goes to idle and the FSM goes to inicial.
- rx passes through a 2-FF synchronizer before any use.
- Byte RX:
  - A falling edge on the synchronized rx in idle starts a DIV/2 count.
  - At mid-start, rx=1 means a glitch: return to idle, no output.
  - Otherwise sample 8 data bits LSB-first at DIV intervals, then the stop bit.
  - Stop=1: byte_pronto pulses for 1 cycle with dado valid.
  - Stop=0: erro_byte pulses for 1 cycle and the byte is dropped.
  - Receiver is ready for the next falling edge after the stop sample.
- Frame FSM (db_estado code); each transition consumes one byte_pronto.
  - inicial (0): digit '0'-'9' stores hundreds, idx=1, go to recebe_angulo. '#' stays in inicial. Anything else goes to sincroniza.
  - recebe_angulo (1): a digit is stored at idx; after idx=2 go to recebe_virgula.
  - recebe_virgula (2): ',' goes to recebe_distancia with idx=0.
  - recebe_distancia (3): 4 digits, thousands first; after the 4th go to recebe_fim.
  - recebe_fim (4): '#' goes to valido.
  - valido (5): lasts 1 cycle. angulo/distancia load from shadow registers on entry and quadro_pronto=1 in this cycle. Then go to inicial.
  - sincroniza (E): discard bytes until '#', then go to inicial.
- Errors in states 1-4:
  - An unexpected non-'#' byte pulses erro_quadro and goes to sincroniza.
  - An unexpected '#' pulses erro_quadro and goes directly to inicial, because the terminator is already consumed.
- erro_byte in any state except inicial/sincroniza: erro_quadro pulse, go to sincroniza. In inicial/sincroniza it is ignored.
- erro_quadro asserts in the cycle after the offending byte_pronto/erro_byte.
- Digit conversion: dado-8'h30, low nibble only. Shadow registers never drive outputs directly.
- habilita falling mid-frame: FSM goes to inicial on the next edge, no error pulse, outputs hold. Byte RX keeps running.
- Latency: quadro_pronto rises 1 clock after byte_pronto for '#'.
- Outputs are registered and change only in valido or at reset.
- Reset mid-byte or mid-frame aborts immediately; the next start bit is processed normally.

Decomposition:
- Package sonar_rx_pkg: ASCII constants (ASCII_0=8'h30, ASCII_9=8'h39, ASCII_VIRGULA=8'h2C, ASCII_FIM=8'h23), frame FSM state encodings, and the DIV derivation function.
- One sub-module, uart_rx_byte: synchronizer, bit timer, shift register, byte_pronto/erro_byte.
- Frame FSM, shadow registers and outputs stay in sonar_rx_quadro.

Test Plan:
- Reset then frame "090,0123#" at 115200 -> quadro_pronto one pulse; angulo=12'h090; distancia=16'h0123; erro_quadro never asserted.
- Two back-to-back frames "045,0020#" then "180,1500#" with zero idle between bytes -> two pulses; final angulo=12'h180, distancia=16'h1500.
- "09X,0123#" -> single erro_quadro pulse after 'X'; '#' consumed in sincroniza; angulo/distancia unchanged; following "010,0005#" publishes 12'h010/16'h0005.
- "090,01#" -> erro_quadro pulse after '#', FSM directly to inicial, next valid frame accepted.
- 200 ns low glitch on rx, then byte 0x30 with stop bit forced 0 inside a frame -> glitch ignored; erro_quadro pulse; db_estado=4'hE.
- Assert reset (0) midway through the 5th byte, release, send "135,0999#" -> outputs 0 during reset, then angulo=12'h135, distancia=16'h0999; habilita=0 during a full frame -> no pulses, db_estado=0.

Source files
------------

// File: rtl/sonar_rx_quadro_pkg.sv
// Shared constants for the sonar serial receiver: ASCII symbols of the
// "AAA,DDDD#" frame, FSM encodings and the bit-period derivation.
package sonar_rx_pkg;

  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam logic [7:0] ASCII_VIRGULA = 8'h2C;
  localparam logic [7:0] ASCII_FIM     = 8'h23;

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    RECEBE_ANGULO    = 4'h1,
    RECEBE_VIRGULA   = 4'h2,
    RECEBE_DISTANCIA = 4'h3,
    RECEBE_FIM       = 4'h4,
    VALIDO           = 4'h5,
    SINCRONIZA       = 4'hE
  } estado_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_estado_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sonar_rx_quadro_uart_rx_byte.sv
// 8N1 byte deserializer: 2-FF synchronizer, mid-bit sampling timer and
// shift register; reports good bytes and stop-bit errors as 1-cycle pulses.
module uart_rx_byte
  import sonar_rx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       byte_pronto,
  output logic       erro_byte
);

  localparam int          DIV     = calc_div(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  rx_estado_t  estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_pronto_q, byte_pronto_d;
  logic        erro_byte_q, erro_byte_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      estado_q      <= RX_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      byte_pronto_q <= 1'b0;
      erro_byte_q   <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      byte_pronto_q <= byte_pronto_d;
      erro_byte_q   <= erro_byte_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    byte_pronto_d = 1'b0;
    erro_byte_d   = 1'b0;
    case (estado_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_prev_q && !rx_sync_q) estado_d = RX_START;
      end
      RX_START: begin
        // A line back high at mid-start was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          estado_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) estado_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d         = '0;
          estado_d      = RX_IDLE;
          byte_pronto_d = rx_sync_q;
          erro_byte_d   = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: estado_d = RX_IDLE;
    endcase
  end

  assign dado        = shift_q;
  assign byte_pronto = byte_pronto_q;
  assign erro_byte   = erro_byte_q;

endmodule

// File: rtl/sonar_rx_quadro.sv
// Sonar link receiver: parses "AAA,DDDD#" into BCD angle/distance, pulses on
// good and malformed frames, and resynchronizes on the '#' terminator.
module sonar_rx_quadro
  import sonar_rx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic        rx,
  output logic [11:0] angulo,
  output logic [15:0] distancia,
  output logic        quadro_pronto,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
);

  logic [7:0] dado;
  logic       byte_pronto, erro_byte;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .dado        (dado),
    .byte_pronto (byte_pronto),
    .erro_byte   (erro_byte)
  );

  estado_t     estado_q, estado_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] ang_sh_q, ang_sh_d, angulo_q, angulo_d;
  logic [15:0] dist_sh_q, dist_sh_d, distancia_q, distancia_d;
  logic        quadro_pronto_q, quadro_pronto_d;
  logic        erro_quadro_q, erro_quadro_d;
  logic        is_digit, is_fim, aceito;
  logic [3:0]  nib;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q        <= INICIAL;
      idx_q           <= '0;
      ang_sh_q        <= '0;
      dist_sh_q       <= '0;
      angulo_q        <= '0;
      distancia_q     <= '0;
      quadro_pronto_q <= 1'b0;
      erro_quadro_q   <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      idx_q           <= idx_d;
      ang_sh_q        <= ang_sh_d;
      dist_sh_q       <= dist_sh_d;
      angulo_q        <= angulo_d;
      distancia_q     <= distancia_d;
      quadro_pronto_q <= quadro_pronto_d;
      erro_quadro_q   <= erro_quadro_d;
    end
  end

  always_comb begin
    estado_d        = estado_q;
    idx_d           = idx_q;
    ang_sh_d        = ang_sh_q;
    dist_sh_d       = dist_sh_q;
    angulo_d        = angulo_q;
    distancia_d     = distancia_q;
    quadro_pronto_d = 1'b0;
    erro_quadro_d   = 1'b0;
    aceito          = 1'b0;
    is_digit        = (dado >= ASCII_0) && (dado <= ASCII_9);
    is_fim          = (dado == ASCII_FIM);
    nib             = 4'(dado - ASCII_0);
    if (!habilita) begin
      estado_d = INICIAL;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (byte_pronto) begin
            if (is_digit) begin
              ang_sh_d[11:8] = nib;
              idx_d          = 2'd1;
              estado_d       = RECEBE_ANGULO;
            end else if (!is_fim) begin
              estado_d = SINCRONIZA;
            end
          end
        end
        SINCRONIZA: begin
          if (byte_pronto && is_fim) estado_d = INICIAL;
        end
        VALIDO: begin
          if (erro_byte) begin
            erro_quadro_d = 1'b1;
            estado_d      = SINCRONIZA;
          end else begin
            estado_d = INICIAL;
          end
        end
        default: begin
          if (erro_byte) begin
            erro_quadro_d = 1'b1;
            estado_d      = SINCRONIZA;
          end else if (byte_pronto) begin
            case (estado_q)
              RECEBE_ANGULO: if (is_digit) begin
                aceito = 1'b1;
                if (idx_q == 2'd1) ang_sh_d[7:4] = nib;
                else               ang_sh_d[3:0] = nib;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd2) estado_d = RECEBE_VIRGULA;
              end
              RECEBE_VIRGULA: if (dado == ASCII_VIRGULA) begin
                aceito   = 1'b1;
                idx_d    = 2'd0;
                estado_d = RECEBE_DISTANCIA;
              end
              RECEBE_DISTANCIA: if (is_digit) begin
                aceito = 1'b1;
                case (idx_q)
                  2'd0:    dist_sh_d[15:12] = nib;
                  2'd1:    dist_sh_d[11:8]  = nib;
                  2'd2:    dist_sh_d[7:4]   = nib;
                  default: dist_sh_d[3:0]   = nib;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) estado_d = RECEBE_FIM;
              end
              RECEBE_FIM: if (is_fim) begin
                // Outputs load as VALIDO is entered, so the pulse and data align.
                aceito          = 1'b1;
                angulo_d        = ang_sh_q;
                distancia_d     = dist_sh_q;
                quadro_pronto_d = 1'b1;
                estado_d        = VALIDO;
              end
              default: aceito = 1'b0;
            endcase
            // A stray '#' already ended the frame, so no resync is needed.
            if (!aceito) begin
              erro_quadro_d = 1'b1;
              estado_d      = is_fim ? INICIAL : SINCRONIZA;
            end
          end
        end
      endcase
    end
  end

  assign angulo        = angulo_q;
  assign distancia     = distancia_q;
  assign quadro_pronto = quadro_pronto_q;
  assign erro_quadro   = erro_quadro_q;
  assign db_estado     = estado_q;

endmodule
